multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle control unit for the ARM CPU core. It replaces the single-cycle Controller with a state-machine controller that sequences each instruction through fetch, decode, execute, memory and writeback cycles, and shares one ALU and one memory port across those cycles. It keeps the single-cycle block's decode encodings, conditional execution and NZCV flag handling. It adds a parametrised memory wait-state handshake and exposes its state for debug.

## Interface
Parameters:
- MEM_WAIT, default 0: 0 means memory completes in one cycle and mem_ready is ignored; 1 means FETCH, MEMRD and MEMWR hold until mem_ready=1.
- FLAGS_INIT, default 4'b0000: NZCV value loaded on reset.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- op  in  2  instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 unsupported.
- funct  in  6  instr[25:20]; I, cmd[3:0], S (for memory ops: I̅, P, U, B, W, L).
- rd  in  4  instr[15:12].
- cond  in  4  instr[31:28].
- alu_flags  in  4  NZCV from the ALU in the current cycle.
- mem_ready  in  1  memory access completes this cycle.
- pc_write, ir_write, reg_write, mem_write  out  1 each  write enables.
- adr_src  out  1  0 selects PC, 1 selects ALU result register.
- alu_src_a  out  1  0 selects Rn, 1 selects PC.
- alu_src_b  out  2  00 selects reg, 01 selects ext-imm, 10 selects constant 4.
- result_src  out  2  00 selects ALUOut reg, 01 selects read data, 10 selects ALU result direct.
- imm_src, reg_src  out  2 each  immediate format and register-address mux selects.
- alu_ctl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 ADC.
- shift, carry, swap, inv  out  1 each  shifter pass, carry-in, operand swap, operand invert.
- state_o  out  4  current state encoding.

## Operation
States and encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Codes 10–15 are illegal and go to FETCH on the next edge.

Transitions:
- FETCH → DECODE.
- DECODE, by op: 01 → MEMADR; 00 with funct[5]=0 → EXECR; 00 with funct[5]=1 → EXECI; 10 → BRANCH; 11 → FETCH.
- MEMADR: → MEMRD if funct[0] (L) is 1, else → MEMWR.
- MEMRD → MEMWB.
- EXECR and EXECI → ALUWB.
- MEMWB, MEMWR, ALUWB and BRANCH → FETCH.
- With MEM_WAIT=1, FETCH, MEMRD and MEMWR stay in their state while mem_ready=0.

Per-state outputs (anything not listed is 0):
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10, alu_ctl=ADD. ir_write and pc_write are asserted only in the completing cycle (always with MEM_WAIT=0, when mem_ready=1 with MEM_WAIT=1).
- DECODE: alu_src_a=1, alu_src_b=10, alu_ctl=ADD, which forms PC+8.
- MEMADR: alu_src_b=01, alu_ctl=ADD.
- MEMRD: adr_src=1.
- MEMWR: adr_src=1; mem_write = cond_ex_q, held for every cycle spent in MEMWR.
- MEMWB: result_src=01; reg_write = cond_ex_q; pc_write = cond_ex_q & (rd==15).
- EXECR/EXECI: alu_src_b=00 or 01 respectively; ALU decode active.
- ALUWB: result_src=00; reg_write = cond_ex_q & !no_write; pc_write = reg_write & (rd==15).
- BRANCH: alu_src_b=01, alu_ctl=ADD, result_src=10; pc_write = cond_ex_q.

Registered/static decode outputs:
- imm_src = op, valid in all states.
- reg_src = {op==01, op==10}.

ALU decode (EXECR/EXECI only), by cmd:
- 0100 ADD → 000.
- 0010 SUB and 1010 CMP → 001.
- 0011 RSB → 001 with swap=1.
- 0000 AND → 010.
- 1100 ORR → 011.
- 0101 ADC → 100 with carry = flags_q.C.
- 1101 MOV → shift=1.
- 1111 MVN → shift=1, inv=1.
- Any other cmd → ADD.
- no_write=1 for CMP.

Condition handling:
- cond_ex is the standard ARM condition evaluated against flags_q; 1110 is always true, 1111 is false.
- cond_ex is latched into cond_ex_q at the end of DECODE. All gating in later states uses cond_ex_q, so a flag update in EXEC never changes the current instruction's condition.

Flag update, at the end of EXECR/EXECI when cond_ex_q=1 and S=1:
- N and Z are always written from alu_flags.
- C and V are written only for ADD, SUB, RSB, ADC and CMP.
- CMP updates flags whenever cond_ex_q=1, regardless of S.

## Timing
- Reset: on an edge with reset=1, state becomes FETCH, flags_q becomes FLAGS_INIT and cond_ex_q becomes 0.
- While reset=1, all write enables (pc_write, ir_write, reg_write, mem_write) are forced to 0 and the other outputs show FETCH values.
- Reset asserted in any state aborts the instruction without any write in that cycle.
- Latency with MEM_WAIT=0: data-processing 4 cycles, LDR 5, STR 4, B 3, op=11 2.
- Each wait cycle with MEM_WAIT=1 adds one cycle. Writes are asserted only in the cycle whose edge commits them.
- Outputs are combinational from state, cond_ex_q, flags_q and the instruction fields. There is no output register.

## Test plan
- Reset held 2 cycles, then released: state_o=0, all enables 0 during reset, flags_q=FLAGS_INIT. The first cycle after release shows ir_write=1 and pc_write=1.
- ADD register op (op=00, funct=001000, cond=1110): state_o sequence 0,1,6,8,0; alu_ctl=000 in EXECR; reg_write=1 only in ALUWB; pc_write in ALUWB only if rd=15.
- LDR (op=01, funct=011001) with MEM_WAIT=1 and mem_ready low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0; result_src=01 and reg_write=1 in MEMWB.
- SUBS with S=1, alu_flags=0100 in EXEC, followed by BEQ (cond=0000): flags_q.Z=1 and the branch gives pc_write=1 in BRANCH. Repeat with Z=0: pc_write=0.
- STR with cond=0001 (NE) and Z=1: MEMWR is entered but mem_write=0 throughout.
- ADC with flags_q.C=1: carry=1, alu_ctl=100. RSB: swap=1. MVN: shift=1, inv=1. CMP: reg_write=0 in ALUWB, flags updated.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/memory/writeback over a shared ALU and memory port.
// Latency: DP 4, LDR 5, STR 4, B 3, unsupported 2 cycles, plus one per memory wait cycle when MEM_WAIT=1.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0 (MEM_WAIT=1 only); no other stalls.
module multicycle_controller #(
    parameter int          MEM_WAIT   = 0,
    parameter logic [3:0]  FLAGS_INIT = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [2:0] alu_ctl,
    output logic       shift,
    output logic       carry,
    output logic       swap,
    output logic       inv,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_ADC = 3'b100;

    state_t     state, state_n, cur;
    logic [3:0] flags_q;
    logic       cond_ex, cond_ex_q;
    logic       n_f, z_f, c_f, v_f;
    logic       mem_done;
    logic [3:0] cmd;
    logic       s_bit, is_cmp;
    logic [2:0] dec_ctl;
    logic       dec_shift, dec_carry, dec_swap, dec_inv, no_write, cv_upd;

    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign mem_done = (MEM_WAIT == 0) || mem_ready;
    assign cmd      = funct[4:1];
    assign s_bit    = funct[0];
    assign is_cmp   = (cmd == 4'b1010);
    // Reset shows FETCH outputs immediately, without waiting for the edge.
    assign cur      = reset ? FETCH : state;
    assign state_o  = cur;
    assign imm_src  = op;
    assign reg_src  = {op == 2'b01, op == 2'b10};

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !c_f || z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = z_f || (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        dec_ctl   = ALU_ADD;
        dec_shift = 1'b0;
        dec_carry = 1'b0;
        dec_swap  = 1'b0;
        dec_inv   = 1'b0;
        no_write  = 1'b0;
        cv_upd    = 1'b0;
        case (cmd)
            4'b0100: cv_upd = 1'b1;
            4'b0010: begin dec_ctl = ALU_SUB; cv_upd = 1'b1; end
            4'b1010: begin dec_ctl = ALU_SUB; cv_upd = 1'b1; no_write = 1'b1; end
            4'b0011: begin dec_ctl = ALU_SUB; cv_upd = 1'b1; dec_swap = 1'b1; end
            4'b0000: dec_ctl = ALU_AND;
            4'b1100: dec_ctl = ALU_ORR;
            4'b0101: begin dec_ctl = ALU_ADC; cv_upd = 1'b1; dec_carry = c_f; end
            4'b1101: dec_shift = 1'b1;
            4'b1111: begin dec_shift = 1'b1; dec_inv = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_n    = FETCH;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_ctl    = ALU_ADD;
        shift      = 1'b0;
        carry      = 1'b0;
        swap       = 1'b0;
        inv        = 1'b0;
        case (cur)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_n    = FETCH;
                if (mem_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op)
                    2'b01:   state_n = MEMADR;
                    2'b00:   state_n = funct[5] ? EXECI : EXECR;
                    2'b10:   state_n = BRANCH;
                    default: state_n = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b = 2'b01;
                state_n   = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                state_n = mem_done ? MEMWB : MEMRD;
            end
            MEMWR: begin
                adr_src   = 1'b1;
                mem_write = cond_ex_q;
                state_n   = mem_done ? FETCH : MEMWR;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = cond_ex_q;
                pc_write   = cond_ex_q && (rd == 4'd15);
            end
            EXECR, EXECI: begin
                alu_src_b = (cur == EXECI) ? 2'b01 : 2'b00;
                alu_ctl   = dec_ctl;
                shift     = dec_shift;
                carry     = dec_carry;
                swap      = dec_swap;
                inv       = dec_inv;
                state_n   = ALUWB;
            end
            ALUWB: begin
                reg_write = cond_ex_q && !no_write;
                pc_write  = cond_ex_q && !no_write && (rd == 4'd15);
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex_q;
            end
            default: state_n = FETCH;
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            flags_q   <= FLAGS_INIT;
            cond_ex_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DECODE)
                cond_ex_q <= cond_ex;
            // CMP exists only to set flags, so it ignores S.
            if ((state == EXECR || state == EXECI) && cond_ex_q && (s_bit || is_cmp)) begin
                flags_q[3:2] <= alu_flags[3:2];
                if (cv_upd)
                    flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one wait-state instance (MEM_WAIT=1) checked in depth,
// plus a zero-wait instance to confirm mem_ready is ignored there.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd, cond, alu_flags;
    logic       mem_ready;

    logic       pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, reg_src;
    logic [2:0] alu_ctl;
    logic       shift, carry, swap, inv;
    logic [3:0] state_o;

    logic       d0_pc_write, d0_ir_write, d0_reg_write, d0_mem_write, d0_adr_src, d0_alu_src_a;
    logic [1:0] d0_alu_src_b, d0_result_src, d0_imm_src, d0_reg_src;
    logic [2:0] d0_alu_ctl;
    logic       d0_shift, d0_carry, d0_swap, d0_inv;
    logic [3:0] d0_state_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_WAIT(1), .FLAGS_INIT(4'b0010)) dut1 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond(cond),
        .alu_flags(alu_flags), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .reg_src(reg_src), .alu_ctl(alu_ctl), .shift(shift), .carry(carry),
        .swap(swap), .inv(inv), .state_o(state_o)
    );

    multicycle_controller #(.MEM_WAIT(0), .FLAGS_INIT(4'b0000)) dut0 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond(cond),
        .alu_flags(alu_flags), .mem_ready(mem_ready),
        .pc_write(d0_pc_write), .ir_write(d0_ir_write), .reg_write(d0_reg_write),
        .mem_write(d0_mem_write), .adr_src(d0_adr_src), .alu_src_a(d0_alu_src_a),
        .alu_src_b(d0_alu_src_b), .result_src(d0_result_src), .imm_src(d0_imm_src),
        .reg_src(d0_reg_src), .alu_ctl(d0_alu_ctl), .shift(d0_shift), .carry(d0_carry),
        .swap(d0_swap), .inv(d0_inv), .state_o(d0_state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // en = {pc_write, ir_write, reg_write, mem_write}
    task automatic cyc(input string tag, input logic [3:0] st, input logic [3:0] en);
        #1;
        chk({tag, ".state"}, {28'd0, state_o}, {28'd0, st});
        chk({tag, ".en"}, {28'd0, pc_write, ir_write, reg_write, mem_write}, {28'd0, en});
        step;
    endtask

    task automatic set_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                             input logic [3:0] c);
        op = o; funct = f; rd = r; cond = c;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst.state", {28'd0, state_o}, 32'd0);
            chk("rst.en", {28'd0, pc_write, ir_write, reg_write, mem_write}, 32'd0);
            chk("rst.d0_en", {28'd0, d0_pc_write, d0_ir_write, d0_reg_write, d0_mem_write}, 32'd0);
            step;
        end
        reset = 1'b0;
        #1;
        chk("rst.flags", {28'd0, dut1.flags_q}, 32'h2);
        chk("rst.first_fetch", {30'd0, ir_write, pc_write}, 32'h3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mem_ready = 1'b1;
        alu_flags = 4'h0;
        set_instr(2'b11, 6'b000000, 4'd0, 4'hE);
        do_reset;

        // Wait-state FETCH versus zero-wait instance
        mem_ready = 1'b0;
        #1;
        chk("wait.fetch_ir", {31'd0, ir_write}, 32'd0);
        chk("wait.fetch_pc", {31'd0, pc_write}, 32'd0);
        chk("nowait.fetch_ir", {31'd0, d0_ir_write}, 32'd1);
        step;
        chk("wait.fetch_hold", {28'd0, state_o}, 32'd0);
        chk("nowait.decode", {28'd0, d0_state_o}, 32'd1);
        mem_ready = 1'b1;
        do_reset;

        // ADD, S=0: flags must not change even with alu_flags all ones
        alu_flags = 4'hF;
        set_instr(2'b00, 6'b001000, 4'd3, 4'hE);
        cyc("add.f", 4'd0, 4'b1100);
        cyc("add.d", 4'd1, 4'b0000);
        #1;
        chk("add.alu_ctl", {29'd0, alu_ctl}, 32'd0);
        chk("add.srcb", {30'd0, alu_src_b}, 32'd0);
        cyc("add.x", 4'd6, 4'b0000);
        #1;
        chk("add.res_src", {30'd0, result_src}, 32'd0);
        cyc("add.wb", 4'd8, 4'b0010);
        chk("add.flags", {28'd0, dut1.flags_q}, 32'h2);

        set_instr(2'b00, 6'b001000, 4'd15, 4'hE);
        cyc("addpc.f", 4'd0, 4'b1100);
        cyc("addpc.d", 4'd1, 4'b0000);
        cyc("addpc.x", 4'd6, 4'b0000);
        cyc("addpc.wb", 4'd8, 4'b1010);

        // LDR with two memory wait cycles
        set_instr(2'b01, 6'b011001, 4'd2, 4'hE);
        cyc("ldr.f", 4'd0, 4'b1100);
        #1;
        chk("ldr.reg_src", {30'd0, reg_src}, 32'h2);
        cyc("ldr.d", 4'd1, 4'b0000);
        #1;
        chk("ldr.srcb", {30'd0, alu_src_b}, 32'h1);
        cyc("ldr.a", 4'd2, 4'b0000);
        mem_ready = 1'b0;
        #1;
        chk("ldr.adr_src", {31'd0, adr_src}, 32'd1);
        cyc("ldr.r0", 4'd3, 4'b0000);
        cyc("ldr.r1", 4'd3, 4'b0000);
        mem_ready = 1'b1;
        cyc("ldr.r2", 4'd3, 4'b0000);
        #1;
        chk("ldr.res_src", {30'd0, result_src}, 32'h1);
        cyc("ldr.wb", 4'd4, 4'b0010);
        #1;
        chk("ldr.end", {28'd0, state_o}, 32'd0);

        // SUBS setting Z, then BEQ taken
        alu_flags = 4'b0100;
        set_instr(2'b00, 6'b000101, 4'd1, 4'hE);
        cyc("subs.f", 4'd0, 4'b1100);
        cyc("subs.d", 4'd1, 4'b0000);
        #1;
        chk("subs.alu_ctl", {29'd0, alu_ctl}, 32'h1);
        cyc("subs.x", 4'd6, 4'b0000);
        cyc("subs.wb", 4'd8, 4'b0010);
        chk("subs.flags", {28'd0, dut1.flags_q}, 32'h4);
        alu_flags = 4'h0;
        set_instr(2'b10, 6'b000000, 4'd0, 4'b0000);
        cyc("beq.f", 4'd0, 4'b1100);
        cyc("beq.d", 4'd1, 4'b0000);
        #1;
        chk("beq.srcb", {30'd0, alu_src_b}, 32'h1);
        chk("beq.res_src", {30'd0, result_src}, 32'h2);
        cyc("beq.br", 4'd9, 4'b1000);

        // SUBS clearing Z, then BEQ not taken
        set_instr(2'b00, 6'b000101, 4'd1, 4'hE);
        cyc("subs2.f", 4'd0, 4'b1100);
        cyc("subs2.d", 4'd1, 4'b0000);
        cyc("subs2.x", 4'd6, 4'b0000);
        cyc("subs2.wb", 4'd8, 4'b0010);
        set_instr(2'b10, 6'b000000, 4'd0, 4'b0000);
        cyc("bne.f", 4'd0, 4'b1100);
        cyc("bne.d", 4'd1, 4'b0000);
        cyc("bne.br", 4'd9, 4'b0000);

        // STRNE with Z=1: MEMWR entered, no write
        alu_flags = 4'b0100;
        set_instr(2'b00, 6'b000101, 4'd1, 4'hE);
        cyc("subs3.f", 4'd0, 4'b1100);
        cyc("subs3.d", 4'd1, 4'b0000);
        cyc("subs3.x", 4'd6, 4'b0000);
        cyc("subs3.wb", 4'd8, 4'b0010);
        alu_flags = 4'h0;
        set_instr(2'b01, 6'b011000, 4'd4, 4'b0001);
        cyc("strne.f", 4'd0, 4'b1100);
        cyc("strne.d", 4'd1, 4'b0000);
        cyc("strne.a", 4'd2, 4'b0000);
        mem_ready = 1'b0;
        cyc("strne.w0", 4'd5, 4'b0000);
        mem_ready = 1'b1;
        cyc("strne.w1", 4'd5, 4'b0000);

        // STR always: mem_write held across the wait
        set_instr(2'b01, 6'b011000, 4'd4, 4'hE);
        cyc("str.f", 4'd0, 4'b1100);
        cyc("str.d", 4'd1, 4'b0000);
        cyc("str.a", 4'd2, 4'b0000);
        mem_ready = 1'b0;
        cyc("str.w0", 4'd5, 4'b0001);
        mem_ready = 1'b1;
        cyc("str.w1", 4'd5, 4'b0001);
        #1;
        chk("str.end", {28'd0, state_o}, 32'd0);

        // ALU decode variants from reset flags (C=1)
        do_reset;
        set_instr(2'b00, 6'b001010, 4'd5, 4'hE);
        cyc("adc.f", 4'd0, 4'b1100);
        cyc("adc.d", 4'd1, 4'b0000);
        #1;
        chk("adc.alu_ctl", {29'd0, alu_ctl}, 32'h4);
        chk("adc.carry", {31'd0, carry}, 32'd1);
        cyc("adc.x", 4'd6, 4'b0000);
        cyc("adc.wb", 4'd8, 4'b0010);

        set_instr(2'b00, 6'b000110, 4'd5, 4'hE);
        cyc("rsb.f", 4'd0, 4'b1100);
        cyc("rsb.d", 4'd1, 4'b0000);
        #1;
        chk("rsb.alu_ctl", {29'd0, alu_ctl}, 32'h1);
        chk("rsb.swap", {31'd0, swap}, 32'd1);
        cyc("rsb.x", 4'd6, 4'b0000);
        cyc("rsb.wb", 4'd8, 4'b0010);

        set_instr(2'b00, 6'b111110, 4'd5, 4'hE);
        cyc("mvn.f", 4'd0, 4'b1100);
        cyc("mvn.d", 4'd1, 4'b0000);
        #1;
        chk("mvn.shift_inv", {30'd0, shift, inv}, 32'h3);
        chk("mvn.srcb", {30'd0, alu_src_b}, 32'h1);
        cyc("mvn.x", 4'd7, 4'b0000);
        cyc("mvn.wb", 4'd8, 4'b0010);

        // CMP with S=0 still updates flags; no register write
        alu_flags = 4'b1001;
        set_instr(2'b00, 6'b010100, 4'd5, 4'hE);
        cyc("cmp.f", 4'd0, 4'b1100);
        cyc("cmp.d", 4'd1, 4'b0000);
        #1;
        chk("cmp.alu_ctl", {29'd0, alu_ctl}, 32'h1);
        cyc("cmp.x", 4'd6, 4'b0000);
        cyc("cmp.wb", 4'd8, 4'b0000);
        chk("cmp.flags", {28'd0, dut1.flags_q}, 32'h9);
        alu_flags = 4'h0;

        // GE true / LT false with N=V=1
        set_instr(2'b00, 6'b001000, 4'd6, 4'b1010);
        cyc("ge.f", 4'd0, 4'b1100);
        cyc("ge.d", 4'd1, 4'b0000);
        cyc("ge.x", 4'd6, 4'b0000);
        cyc("ge.wb", 4'd8, 4'b0010);
        set_instr(2'b00, 6'b001000, 4'd6, 4'b1011);
        cyc("lt.f", 4'd0, 4'b1100);
        cyc("lt.d", 4'd1, 4'b0000);
        cyc("lt.x", 4'd6, 4'b0000);
        cyc("lt.wb", 4'd8, 4'b0000);

        // Unsupported op: two cycles
        set_instr(2'b11, 6'b000000, 4'd0, 4'hE);
        cyc("op3.f", 4'd0, 4'b1100);
        cyc("op3.d", 4'd1, 4'b0000);
        #1;
        chk("op3.end", {28'd0, state_o}, 32'd0);

        // Reset in MEMWR aborts the store
        set_instr(2'b01, 6'b011000, 4'd4, 4'hE);
        cyc("stra.f", 4'd0, 4'b1100);
        cyc("stra.d", 4'd1, 4'b0000);
        cyc("stra.a", 4'd2, 4'b0000);
        mem_ready = 1'b0;
        #1;
        chk("stra.memwr", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        chk("stra.rst_mw", {31'd0, mem_write}, 32'd0);
        chk("stra.rst_state", {28'd0, state_o}, 32'd0);
        step;
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("stra.after", {28'd0, state_o}, 32'd0);
        chk("stra.after_mw", {31'd0, mem_write}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
